// File: rtl/apb_slave_mem.sv
// APB4 completer memory with byte-strobed writes, registered PRDATA/PREADY/PSLVERR and address/alignment errors.
// Define APB_SLV_WAIT_EN to compile in the WAIT_CYCLES wait-state counter; otherwise every transfer is zero-wait.

module apb_slave_mem #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   input  logic [3:0]  PSTRB,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

   state_t        r_state;
   logic [31:0]   r_prdata;
   logic          r_pready;
   logic          r_pslverr;
   logic [31:0]   r_mem [DEPTH];

   logic          w_setup;
   logic          w_err_now;
   logic [AW-1:0] w_idx_now;
   logic          w_fire;
   logic          w_op_write;
   logic          w_op_err;
   logic [AW-1:0] w_op_idx;
   logic [31:0]   w_op_wdata;
   logic [3:0]    w_op_strb;

   assign w_setup   = PSEL & ~PENABLE;
   assign w_err_now = (PADDR[1:0] != 2'b00) || (PADDR >= ADDR_LIMIT);
   assign w_idx_now = PADDR[2 +: AW];

`ifdef APB_SLV_WAIT_EN
   localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);

   logic [3:0]    r_cnt;
   logic          r_write;
   logic          r_err;
   logic [AW-1:0] r_idx;
   logic [31:0]   r_wdata;
   logic [3:0]    r_strb;
   logic          w_in_access;

   assign w_in_access = (r_state == ST_ACCESS);
   assign w_fire      = (~w_in_access & w_setup & ZERO_WAIT) |
                        (w_in_access & PSEL & (r_cnt == 4'd1));
`else
   // Always true: the zero-wait build ignores WAIT_CYCLES.
   localparam bit ZERO_WAIT = (WAIT_CYCLES >= 0);

   assign w_fire = (r_state != ST_ACCESS) & w_setup & ZERO_WAIT;
`endif

   // Zero-wait completions use the live setup-phase bus; waited ones use the captured copy.
   always_comb begin
      w_op_write = PWRITE;
      w_op_err   = w_err_now;
      w_op_idx   = w_idx_now;
      w_op_wdata = PWDATA;
      w_op_strb  = PSTRB;
`ifdef APB_SLV_WAIT_EN
      if (w_in_access) begin
         w_op_write = r_write;
         w_op_err   = r_err;
         w_op_idx   = r_idx;
         w_op_wdata = r_wdata;
         w_op_strb  = r_strb;
      end
`endif
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state   <= ST_IDLE;
         r_prdata  <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
`ifdef APB_SLV_WAIT_EN
         r_cnt     <= '0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_strb    <= '0;
`endif
         // NOTE: the array is cleared by reset, so it builds as flops rather than an SRAM macro.
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;

         case (r_state)
`ifdef APB_SLV_WAIT_EN
            ST_ACCESS: begin
               if (!PSEL)                r_state <= ST_IDLE;
               else if (r_cnt == 4'd1)   r_state <= ST_DONE;
               else                      r_cnt   <= r_cnt - 4'd1;
            end
`endif
            default: begin
               if (w_setup) begin
`ifdef APB_SLV_WAIT_EN
                  r_cnt   <= WAIT_LD;
                  r_write <= PWRITE;
                  r_err   <= w_err_now;
                  r_idx   <= w_idx_now;
                  r_wdata <= PWDATA;
                  r_strb  <= PSTRB;
`endif
                  r_state <= ZERO_WAIT ? ST_DONE : ST_ACCESS;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
         endcase

         if (w_fire) begin
            r_pready  <= 1'b1;
            r_pslverr <= w_op_err;
            if (w_op_write) begin
               if (!w_op_err)
                  for (int b = 0; b < 4; b++)
                     if (w_op_strb[b]) r_mem[w_op_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
            end else begin
               r_prdata <= w_op_err ? '0 : r_mem[w_op_idx];
            end
         end
      end
   end

   assign PRDATA  = r_prdata;
   assign PREADY  = r_pready;
   assign PSLVERR = r_pslverr;

endmodule
